// File: rtl/test_engine_nic_input_block_pkg.sv
// Shared constants and the receive-FSM state type for the test-engine NIC input block.
package test_engine_nic_input_block_pkg;

    localparam int NIC_CHANNEL_WIDTH    = 32;
    localparam int NIC_HEADER_VALID_BIT = NIC_CHANNEL_WIDTH - 1;
    localparam int NIC_ADDR_WIDTH       = 8;
    localparam int PACKET_DATA_FLITS    = 4;

    // Counter value of the last data flit in a packet.
    localparam logic [1:0] LAST_DATA_FLIT = 2'(PACKET_DATA_FLITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_FULL    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/test_engine_nic_input_control_unit.sv
// Receive FSM, flit counter and PE busy tracking; emits capture enables,
// the dispatch strobe and the registered start/credit pulses.
module test_engine_nic_input_control_unit
    import test_engine_nic_input_block_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_header_bit,
    input  logic       i_zero_credits,
    input  logic       i_done_strobe,
    output logic       o_hdr_cap,
    output logic [3:0] o_flit_cap,
    output logic       o_dispatch,
    output logic       o_start_strobe,
    output logic       o_credit_out
);

    rx_state_e  r_state;
    rx_state_e  w_next_state;
    logic [1:0] r_flit_cnt;
    logic       r_busy;
    logic       r_start;
    logic       r_credit;

    always_comb begin
        w_next_state = r_state;
        o_hdr_cap    = 1'b0;
        o_flit_cap   = '0;
        o_dispatch   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_header_bit) begin
                    o_hdr_cap    = 1'b1;
                    w_next_state = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                o_flit_cap[r_flit_cnt] = 1'b1;
                if (r_flit_cnt == LAST_DATA_FLIT)
                    w_next_state = ST_FULL;
            end
            ST_FULL: begin
                // Registered busy: a done in this same cycle only frees the PE next cycle.
                if (!r_busy && !i_zero_credits) begin
                    o_dispatch   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_flit_cnt <= '0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_credit   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (o_hdr_cap)
                r_flit_cnt <= '0;
            else if (r_state == ST_RECEIVE)
                r_flit_cnt <= r_flit_cnt + 2'd1;
            if (o_dispatch)
                r_busy <= 1'b1;
            else if (i_done_strobe)
                r_busy <= 1'b0;
            r_start  <= o_dispatch;
            r_credit <= o_dispatch;
        end
    end

    assign o_start_strobe = r_start;
    assign o_credit_out   = r_credit;

endmodule

// File: rtl/test_engine_nic_input_block.sv
// Input half of the test-engine NIC: assembles a header + 4 data flits and
// hands them to the PE as wordA/wordB plus the address-shifted header.
module test_engine_nic_input_block
    import test_engine_nic_input_block_pkg::*;
#(
    parameter int CHANNEL_WIDTH = NIC_CHANNEL_WIDTH,
    parameter int ADDR_WIDTH    = NIC_ADDR_WIDTH
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNEL_WIDTH-1:0]   input_channel_din,
    output logic                       credit_out_dout,
    input  logic                       zero_credits_din,
    input  logic                       done_strobe_din,
    output logic                       start_strobe_dout,
    output logic [2*CHANNEL_WIDTH-1:0] wordA_dout,
    output logic [2*CHANNEL_WIDTH-1:0] wordB_dout,
    output logic [CHANNEL_WIDTH-1:0]   shifted_header_dout
);

    localparam int CW     = CHANNEL_WIDTH;
    localparam int HDR_KW = CW - 1 - ADDR_WIDTH;  // header bits surviving the shift

    logic              w_hdr_cap;
    logic [3:0]        w_flit_cap;
    logic              w_dispatch;
    logic [HDR_KW-1:0] r_header_buf;
    logic [2*CW-1:0]   r_buf_a;
    logic [2*CW-1:0]   r_buf_b;
    logic [CW-1:0]     w_shifted_header;

    test_engine_nic_input_control_unit u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .i_header_bit   (input_channel_din[CW-1]),
        .i_zero_credits (zero_credits_din),
        .i_done_strobe  (done_strobe_din),
        .o_hdr_cap      (w_hdr_cap),
        .o_flit_cap     (w_flit_cap),
        .o_dispatch     (w_dispatch),
        .o_start_strobe (start_strobe_dout),
        .o_credit_out   (credit_out_dout)
    );

    // Packet buffer is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_hdr_cap)     r_header_buf      <= input_channel_din[HDR_KW-1:0];
        if (w_flit_cap[0]) r_buf_a[CW-1:0]    <= input_channel_din;
        if (w_flit_cap[1]) r_buf_a[2*CW-1:CW] <= input_channel_din;
        if (w_flit_cap[2]) r_buf_b[CW-1:0]    <= input_channel_din;
        if (w_flit_cap[3]) r_buf_b[2*CW-1:CW] <= input_channel_din;
    end

    assign w_shifted_header = {1'b1, r_header_buf, {ADDR_WIDTH{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            wordA_dout          <= '0;
            wordB_dout          <= '0;
            shifted_header_dout <= '0;
        end else if (w_dispatch) begin
            wordA_dout          <= r_buf_a;
            wordB_dout          <= r_buf_b;
            shifted_header_dout <= w_shifted_header;
        end
    end

endmodule

// File: tb/tb_test_engine_nic_input_block.sv
// Directed bench for the NIC input block with hand-computed expectations.
module tb_test_engine_nic_input_block;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        credit;
    logic        zc;
    logic        done;
    logic        start;
    logic [63:0] word_a;
    logic [63:0] word_b;
    logic [31:0] shdr;

    int n_chk  = 0;
    int n_fail = 0;

    test_engine_nic_input_block #(.CHANNEL_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .input_channel_din   (din),
        .credit_out_dout     (credit),
        .zero_credits_din    (zc),
        .done_strobe_din     (done),
        .start_strobe_dout   (start),
        .wordA_dout          (word_a),
        .wordB_dout          (word_b),
        .shifted_header_dout (shdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives header + 4 data flits; returns in the FULL cycle (t+5) with the channel idle.
    task automatic send_pkt(input logic [31:0] h, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] d3, input logic [31:0] d4);
        din = h;  tick();
        din = d1; tick();
        din = d2; tick();
        din = d3; tick();
        din = d4; tick();
        din = '0;
    endtask

    task automatic pulse_done();
        done = 1'b1; tick();
        done = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] h);
        chk({tag, "_wordA"}, word_a, a);
        chk({tag, "_wordB"}, word_b, b);
        chk({tag, "_shdr"}, {32'h0, shdr}, {32'h0, h});
    endtask

    initial begin
        int n_start;
        int n_credit;
        din = '0; zc = 1'b0; done = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_start", {63'h0, start}, 64'h0);
        chk("rst_credit", {63'h0, credit}, 64'h0);
        chk_out("rst", 64'h0, 64'h0, 32'h0);

        // Single packet, best-case latency
        send_pkt(32'h8000_0102, 32'h11, 32'h22, 32'h33, 32'h44);
        chk("p1_t5_start", {63'h0, start}, 64'h0);
        tick();
        chk("p1_t6_start", {63'h0, start}, 64'h1);
        chk("p1_t6_credit", {63'h0, credit}, 64'h1);
        chk_out("p1", 64'h00000022_00000011, 64'h00000044_00000033, 32'h8001_0200);
        tick();
        chk("p1_t7_start", {63'h0, start}, 64'h0);
        chk("p1_t7_credit", {63'h0, credit}, 64'h0);
        pulse_done();

        // Zero credits held high from t through t+20
        zc = 1'b1;
        send_pkt(32'h8000_0203, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        n_start = 0; n_credit = 0;
        for (int i = 5; i <= 20; i++) begin
            n_start  += int'(start);
            n_credit += int'(credit);
            tick();
        end
        chk("zc_no_start", 64'(n_start), 64'h0);
        chk("zc_no_credit", 64'(n_credit), 64'h0);
        chk_out("zc_hold", 64'h00000022_00000011, 64'h00000044_00000033, 32'h8001_0200);
        zc = 1'b0;
        chk("zc_t21_start", {63'h0, start}, 64'h0);
        tick();
        chk("zc_t22_start", {63'h0, start}, 64'h1);
        chk("zc_t22_credit", {63'h0, credit}, 64'h1);
        chk_out("p2", 64'h000000A2_000000A1, 64'h000000A4_000000A3, 32'h8002_0300);
        tick();

        // PE busy: packet 3 holds in FULL until done
        send_pkt(32'h8000_0304, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        tick(); tick(); tick();
        chk("busy_hold_start", {63'h0, start}, 64'h0);
        chk_out("busy_hold", 64'h000000A2_000000A1, 64'h000000A4_000000A3, 32'h8002_0300);
        pulse_done();  // done at cycle d, now in d+1
        chk("busy_d1_start", {63'h0, start}, 64'h0);
        chk_out("busy_d1", 64'h000000A2_000000A1, 64'h000000A4_000000A3, 32'h8002_0300);
        tick();
        chk("busy_d2_start", {63'h0, start}, 64'h1);
        chk_out("p3", 64'h000000B2_000000B1, 64'h000000B4_000000B3, 32'h8003_0400);
        tick();

        // done arrives in the same cycle the buffer becomes FULL
        send_pkt(32'h8000_0405, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        done = 1'b1;
        n_start = 0; n_credit = 0;
        for (int i = 5; i <= 12; i++) begin
            if (i == 6) chk("sim_t6_start", {63'h0, start}, 64'h0);
            if (i == 7) chk("sim_t7_start", {63'h0, start}, 64'h1);
            n_start  += int'(start);
            n_credit += int'(credit);
            tick();
            done = 1'b0;
        end
        chk("sim_one_start", 64'(n_start), 64'h1);
        chk("sim_one_credit", 64'(n_credit), 64'h1);
        chk_out("p4", 64'h000000C2_000000C1, 64'h000000C4_000000C3, 32'h8004_0500);
        pulse_done();

        // Idle noise: zeros and an MSB-clear flit are not headers
        din = 32'h0;         tick(); tick();
        din = 32'h7FFF_FFFF; tick();
        din = 32'h0;         tick();
        chk("noise_start", {63'h0, start}, 64'h0);
        chk_out("noise", 64'h000000C2_000000C1, 64'h000000C4_000000C3, 32'h8004_0500);
        din = 32'h7FFF_FFFF; tick();
        send_pkt(32'h8000_0506, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
        tick();
        chk("p5_t6_start", {63'h0, start}, 64'h1);
        chk_out("p5", 64'h000000D2_000000D1, 64'h000000D4_000000D3, 32'h8005_0600);
        tick();

        // Headers injected in FULL (PE still busy) are ignored; upper header bits drop out
        send_pkt(32'hFFC0_0001, 32'hE1, 32'hE2, 32'hE3, 32'hE4);
        din = 32'h8000_0FFF; tick();
        din = 32'h8123_4567; tick();
        din = 32'h0;
        done = 1'b1; tick();
        done = 1'b0;
        din = 32'h80FF_FFFF;  // header during the dispatch cycle
        tick();
        din = 32'h0;
        chk("viol_start", {63'h0, start}, 64'h1);
        chk_out("p6", 64'h000000E2_000000E1, 64'h000000E4_000000E3, 32'hC000_0100);
        pulse_done();
        n_start = 0;
        for (int i = 0; i < 10; i++) begin
            n_start += int'(start);
            tick();
        end
        chk("viol_no_extra_start", 64'(n_start), 64'h0);

        // Reset after data flit 2 discards the partial packet
        din = 32'h8000_0708; tick();
        din = 32'hF1;        tick();
        din = 32'hF2;        tick();
        din = 32'h0; reset = 1'b1; tick();
        reset = 1'b0;
        chk("mid_rst_credit", {63'h0, credit}, 64'h0);
        chk("mid_rst_start", {63'h0, start}, 64'h0);
        chk_out("mid_rst", 64'h0, 64'h0, 32'h0);
        n_credit = 0;
        for (int i = 0; i < 8; i++) begin
            n_credit += int'(credit);
            tick();
        end
        chk("mid_rst_no_credit", 64'(n_credit), 64'h0);
        send_pkt(32'h8000_0809, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'h8000_0001);
        tick();
        chk("p8_t6_start", {63'h0, start}, 64'h1);
        chk("p8_t6_credit", {63'h0, credit}, 64'h1);
        chk_out("p8", 64'h9ABCDEF0_12345678, 64'h80000001_FFFFFFFF, 32'h8008_0900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
